// File: rtl/cont_pkg.sv
// Shared types and the next-count function for the modular up/down counter.
package cont_pkg;

    typedef enum logic {WRAP = 1'b0, SAT = 1'b1} modo_t;

    localparam int unsigned MAX_W = 32;

    typedef struct packed {
        logic [MAX_W-1:0] valor;
        logic             fim;
        logic             erro;
    } next_t;

    // Values are widened to MAX_W so that sums never truncate for WIDTH <= 31.
    function automatic next_t next_count(
        input logic [MAX_W-1:0] saida,
        input logic [MAX_W-1:0] passo,
        input logic [MAX_W-1:0] entrada,
        input logic [MAX_W-1:0] modulo,
        input logic             load,
        input logic             enable,
        input logic             up,
        input modo_t            modo
    );
        next_t            res;
        logic [MAX_W-1:0] s;
        res.valor = saida;
        res.fim   = 1'b0;
        res.erro  = 1'b0;
        s         = saida + passo;
        if (load) begin
            if (entrada < modulo) begin
                res.valor = entrada;
            end else begin
                res.valor = modulo - MAX_W'(1);
                res.erro  = 1'b1;
            end
        end else if (enable) begin
            if (passo >= modulo) begin
                res.erro = 1'b1;
            end else if (passo == '0) begin
                res.valor = saida;
            end else if (up) begin
                if (s < modulo) begin
                    res.valor = s;
                end else begin
                    res.fim   = 1'b1;
                    res.valor = (modo == WRAP) ? (s - modulo) : (modulo - MAX_W'(1));
                end
            end else begin
                if (saida >= passo) begin
                    res.valor = saida - passo;
                end else begin
                    res.fim   = 1'b1;
                    res.valor = (modo == WRAP) ? (saida + modulo - passo) : '0;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cont_next.sv
// Combinational next-state for the counter: add/sub, bound check and clamp.
module cont_next
    import cont_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned MODULO = 10
) (
    input  logic [WIDTH-1:0] saida,
    input  logic [WIDTH-1:0] passo,
    input  logic [WIDTH-1:0] entrada,
    input  logic             load,
    input  logic             enable,
    input  logic             up,
    input  modo_t            modo,
    output logic [WIDTH-1:0] valor_c,
    output logic             fim_c,
    output logic             erro_c
);

    next_t res;
    logic  unused_hi;

    always_comb begin
        res = next_count(MAX_W'(saida), MAX_W'(passo), MAX_W'(entrada),
                         MAX_W'(MODULO), load, enable, up, modo);
    end

    assign valor_c   = WIDTH'(res.valor);
    assign fim_c     = res.fim;
    assign erro_c    = res.erro;
    assign unused_hi = ^res.valor[MAX_W-1:WIDTH];

endmodule

// File: rtl/contador_modular.sv
// Modulo-N up/down counter: register stage with async reset around cont_next.
module contador_modular
    import cont_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned MODULO = 10
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             UpDown,
    input  logic             Modo,
    input  logic [WIDTH-1:0] Passo,
    input  logic             Load,
    input  logic [WIDTH-1:0] Entrada,
    output logic [WIDTH-1:0] Saida,
    output logic             Fim,
    output logic             Erro,
    output logic             Zero
);

    if (WIDTH < 2 || WIDTH > MAX_W - 1) begin : g_bad_width
        $error("contador_modular: WIDTH out of range");
    end
    if (MODULO < 2 || 64'(MODULO) > (64'(1) << WIDTH)) begin : g_bad_modulo
        $error("contador_modular: MODULO out of range");
    end

    logic [WIDTH-1:0] saida_q, saida_d;
    logic             fim_q, fim_d;
    logic             erro_q, erro_d;

    cont_next #(
        .WIDTH  (WIDTH),
        .MODULO (MODULO)
    ) u_next (
        .saida   (saida_q),
        .passo   (Passo),
        .entrada (Entrada),
        .load    (Load),
        .enable  (Enable),
        .up      (UpDown),
        .modo    (modo_t'(Modo)),
        .valor_c (saida_d),
        .fim_c   (fim_d),
        .erro_c  (erro_d)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            saida_q <= '0;
            fim_q   <= 1'b0;
            erro_q  <= 1'b0;
        end else begin
            saida_q <= saida_d;
            fim_q   <= fim_d;
            erro_q  <= erro_d;
        end
    end

    assign Saida = saida_q;
    assign Fim   = fim_q;
    assign Erro  = erro_q;
    assign Zero  = (saida_q == '0);

endmodule

// File: tb/tb_contador_modular.sv
// Directed self-checking bench for contador_modular at WIDTH=4, MODULO=10.
module tb_contador_modular;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Enable, UpDown, Modo, Load;
    logic [3:0] Passo, Entrada;
    logic [3:0] Saida;
    logic       Fim, Erro, Zero;

    int n_checks = 0;
    int n_errors = 0;

    contador_modular #(.WIDTH(4), .MODULO(10)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Enable  (Enable),
        .UpDown  (UpDown),
        .Modo    (Modo),
        .Passo   (Passo),
        .Load    (Load),
        .Entrada (Entrada),
        .Saida   (Saida),
        .Fim     (Fim),
        .Erro    (Erro),
        .Zero    (Zero)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled at the next falling edge.
    task automatic tick();
        @(negedge Clock);
    endtask

    task automatic drive(input logic ld, input logic [3:0] ent, input logic en,
                         input logic up, input logic [3:0] ps, input logic md);
        Load = ld; Entrada = ent; Enable = en; UpDown = up; Passo = ps; Modo = md;
    endtask

    task automatic expect_out(input string tag, input int s, input int f, input int e);
        check({tag, ".saida"}, int'(Saida), s);
        check({tag, ".fim"},   int'(Fim),   f);
        check({tag, ".erro"},  int'(Erro),  e);
    endtask

    int seq6 [12] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9, 8};

    initial begin
        Reset = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0);
        #12;
        expect_out("rst0", 0, 0, 0);
        check("rst0.zero", int'(Zero), 1);
        tick();
        Reset = 1'b1;

        // Test 1: async reset while Saida=7, checked before any further edge
        drive(1'b1, 4'd7, 1'b0, 1'b1, 4'd0, 1'b0);
        tick();
        expect_out("t1.load7", 7, 0, 0);
        check("t1.zero_n", int'(Zero), 0);
        Reset = 1'b0;
        #1;
        expect_out("t1.async", 0, 0, 0);
        check("t1.zero", int'(Zero), 1);
        tick();
        Reset = 1'b1;

        // Test 2: load 8, up by 3 with wrap
        drive(1'b1, 4'd8, 1'b0, 1'b1, 4'd3, 1'b0);
        tick();
        expect_out("t2.load", 8, 0, 0);
        drive(1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0);
        tick();
        expect_out("t2.wrap", 1, 1, 0);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0);
        tick();
        expect_out("t2.hold", 1, 0, 0);

        // Test 3: down by 5 from 2 saturating, twice
        drive(1'b1, 4'd2, 1'b0, 1'b0, 4'd5, 1'b1);
        tick();
        expect_out("t3.load", 2, 0, 0);
        drive(1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1);
        tick();
        expect_out("t3.sat1", 0, 1, 0);
        check("t3.zero", int'(Zero), 1);
        tick();
        expect_out("t3.sat2", 0, 1, 0);

        // Test 4: illegal Entrada then illegal Passo
        drive(1'b1, 4'd12, 1'b0, 1'b1, 4'd0, 1'b0);
        tick();
        expect_out("t4.badload", 9, 0, 1);
        drive(1'b0, 4'd0, 1'b1, 1'b1, 4'd10, 1'b0);
        tick();
        expect_out("t4.badpasso", 9, 0, 1);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 4'd10, 1'b0);
        tick();
        expect_out("t4.clear", 9, 0, 0);

        // Saturating up at MODULO-1 keeps flagging; zero step is a no-op
        drive(1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1);
        tick();
        expect_out("sat.top1", 9, 1, 0);
        tick();
        expect_out("sat.top2", 9, 1, 0);
        drive(1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1);
        tick();
        expect_out("passo0", 9, 0, 0);

        // Test 5: load wins over enable, then hold
        drive(1'b1, 4'd4, 1'b1, 1'b1, 4'd3, 1'b0);
        tick();
        expect_out("t5.load", 4, 0, 0);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("t5.hold%0d", i), 4, 0, 0);
        end

        // Down-wrap by 2 across zero: 1 -> 9
        drive(1'b1, 4'd1, 1'b0, 1'b0, 4'd2, 1'b0);
        tick();
        drive(1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0);
        tick();
        expect_out("dnwrap2", 9, 1, 0);

        // Reset mid-count; first enabled edge after release counts from 0
        drive(1'b1, 4'd8, 1'b0, 1'b1, 4'd1, 1'b0);
        tick();
        Reset = 1'b0;
        drive(1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0);
        tick();
        expect_out("midrst", 0, 0, 0);
        Reset = 1'b1;
        tick();
        expect_out("midrst.first", 1, 0, 0);

        // Test 6: down from 0 by 1 with wrap, 12 edges
        drive(1'b1, 4'd0, 1'b0, 1'b0, 4'd1, 1'b0);
        tick();
        drive(1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick();
            expect_out($sformatf("t6.e%0d", i), seq6[i], (seq6[i] == 9) ? 1 : 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
